// File: rtl/pll_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : pll_reset_seq
// Summary  : PLL reset/lock sequencer; holds user logic in reset until lock
//            is stable, retries the PLL on lock timeout, then declares failure.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reset_seq #(
  parameter int RST_PULSE_CYCLES    = 8,
  parameter int LOCK_TIMEOUT_CYCLES = 1000,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       pll_locked,
  input  logic       pwrdwn_req,
  output logic       pll_rst,
  output logic       pll_pwrdwn,
  output logic       user_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count
);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABILIZE = 3'd2,
    S_RUN       = 3'd3,
    S_POWERDOWN = 3'd4,
    S_FAILED    = 3'd5
  } state_t;

  localparam logic [31:0] c_rst_last     = 32'(RST_PULSE_CYCLES - 1);
  localparam logic [31:0] c_timeout_last = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] c_stable_last  = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  c_max_retries  = 4'(MAX_RETRIES);

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        sync1_q, sync2_q;
  logic        locked_s;

  // pll_locked comes from another clock domain
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= S_RESET_PLL;
      cnt_q   <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;

    case (state_q)
      S_RESET_PLL: begin
        if (cnt_q == c_rst_last) begin
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = S_STABILIZE;
        end else if (cnt_q == c_timeout_last) begin
          if (retry_q == c_max_retries) begin
            state_d = S_FAILED;
          end else begin
            retry_d = retry_q + 4'd1;
            state_d = S_RESET_PLL;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_STABILIZE: begin
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == c_stable_last) begin
          state_d = S_RUN;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          state_d = S_RESET_PLL;
        end
      end
      S_POWERDOWN: begin
        if (!pwrdwn_req) begin
          state_d = S_RESET_PLL;
          retry_d = '0;
        end
      end
      S_FAILED: begin
        state_d = S_FAILED;
      end
      default: begin
        state_d = S_RESET_PLL;
        retry_d = '0;
      end
    endcase

    // Power-down beats everything except the terminal failure state
    if (pwrdwn_req && (state_q != S_FAILED)) begin
      state_d = S_POWERDOWN;
      retry_d = retry_q;
    end

    if (state_d != state_q) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    pll_rst    = 1'b1;
    pll_pwrdwn = 1'b0;
    user_rst   = 1'b1;
    ready      = 1'b0;
    fail       = 1'b0;
    case (state_q)
      S_RESET_PLL: pll_rst = 1'b1;
      S_WAIT_LOCK: pll_rst = 1'b0;
      S_STABILIZE: pll_rst = 1'b0;
      S_RUN: begin
        pll_rst  = 1'b0;
        user_rst = 1'b0;
        ready    = 1'b1;
      end
      S_POWERDOWN: pll_pwrdwn = 1'b1;
      S_FAILED:    fail       = 1'b1;
      default:     pll_rst    = 1'b1;
    endcase
  end

  assign retry_count = retry_q;

endmodule
`default_nettype wire
